hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
Parametrised successor of the HI/LO register block. Holds HI/LO and adds an iterative multi-cycle multiplier and divider (signed and unsigned), plus MTHI/MTLO writes and an MFHI/MFLO read port. Sits beside the ALU in the datapath. The control unit stalls the pipeline on `busy`.

Parameters:
- WIDTH, 32, data width of busA/busB/HI/LO.
- MUL_BITS, 1, multiplier bits retired per iteration; legal values 1, 2, 4; must divide WIDTH.
- DIV_BITS, 1, fixed at 1 in this generation; any other value is a compile-time error.

Ports:
- clk  in  1  clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  operation request.
- op  in  3  001 MTLO, 010 MTHI, 011 MULT, 100 MULTU, 101 DIV, 110 DIVU; 000 and 111 are no-op.
- busA  in  WIDTH  rs operand / dividend / MT data.
- busB  in  WIDTH  rt operand / divisor.
- mulRead  in  1  read select: 1 = HI, 0 = LO.
- HI_LOout  out  WIDTH  combinational read of the selected register.
- op_ready  out  1  equals !busy.
- busy  out  1  multiply or divide in flight.
- done  out  1  one-cycle pulse after a MULT/DIV result is committed.
- div_zero  out  1  one-cycle pulse with done when a DIV/DIVU had divisor 0.
- HI_data  out  WIDTH  HI register, debug view.
- LO_data  out  WIDTH  LO register, debug view.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - HI = LO = 0; busy, done, div_zero = 0.
  - Iteration counter and internal operand registers cleared.
  - Any in-flight operation is abandoned with no commit.
- Accept rule: an op is accepted at a rising edge when op_valid && !busy. When busy, op_valid is ignored entirely; MT ops are ignored too. No queueing.
- MTLO / MTHI:
  - LO (resp. HI) <= busA at the accept edge; busy stays 0.
  - No done pulse.
- MULT / MULTU:
  - Accept edge T0: operands latched. Signed ops take magnitudes and record the result sign = sign(A) xor sign(B). busy = 1 after T0.
  - N = WIDTH/MUL_BITS iteration edges T1..TN. Each edge performs shift-add of MUL_BITS multiplier bits into a 2*WIDTH accumulator.
  - At TN: {HI,LO} <= product (negated if the sign flag is set); busy -> 0; done = 1 for the cycle after TN.
- DIV / DIVU:
  - Restoring divider, WIDTH iteration edges, same T0..TN framing.
  - At TN: LO <= quotient, HI <= remainder.
  - Signed: quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - MIN / -1: LO = MIN (wraps), HI = 0.
- Divide by zero:
  - Runs the full WIDTH cycles; HI and LO are NOT written.
  - done and div_zero both pulse for one cycle.
- Back-to-back: a new op may be accepted on the same edge that done is high, because busy is already 0.
- Read: HI_LOout = mulRead ? HI : LO. It is combinational and shows the old value while busy; the consumer must stall on busy.
- Simultaneous events: MT and a MULT/DIV commit can never coincide, because MT is blocked while busy.

Optional Feature:
- Macro HILO_FWD_EN.
- Defined: when op_valid && !busy && op is MTLO/MTHI and the read targets that register, HI_LOout forwards busA in the same cycle. The register write still happens at the edge.
- Undefined: HI_LOout always reflects registered HI/LO only.

Test Plan:
- Reset, then idle read -> HI_LOout = 0, busy = 0, done = 0.
- MULT A=0xFFFFFFFF, B=0x00000002 (WIDTH=32, MUL_BITS=1) -> busy high exactly 32 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE, done 1 cycle.
- MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100/0 after MTHI 0x1234, MTLO 0x5678 -> div_zero and done pulse; HI=0x1234, LO=0x5678 unchanged.
- Mid-MULT: MTHI 0xAAAA issued at cycle 5 -> ignored.
- Mid-MULT: Reset asserted at cycle 10 -> HI=LO=0 immediately, busy=0, no done.
- With HILO_FWD_EN, MTLO 0xDEADBEEF with mulRead=0 -> HI_LOout=0xDEADBEEF in the same cycle. Without the macro -> old LO until after the edge.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register block with iterative shift-add multiplier and restoring divider (signed/unsigned).
// Optional macro HILO_FWD_EN forwards MTHI/MTLO data onto HI_LOout in the issue cycle.
module hilo_muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1,
  parameter int DIV_BITS = 1
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic             mulRead,
  output logic [WIDTH-1:0] HI_LOout,
  output logic             op_ready,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI_data,
  output logic [WIDTH-1:0] LO_data
);

  localparam int N_MUL = WIDTH / MUL_BITS;
  localparam int CW    = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MTLO  = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b010;
  localparam logic [2:0] OP_MULT  = 3'b011;
  localparam logic [2:0] OP_MULTU = 3'b100;
  localparam logic [2:0] OP_DIV   = 3'b101;
  localparam logic [2:0] OP_DIVU  = 3'b110;

  if (DIV_BITS != 1) begin : g_bad_div_bits
    $error("hilo_muldiv_unit: DIV_BITS must be 1");
  end
  if (!(MUL_BITS == 1 || MUL_BITS == 2 || MUL_BITS == 4) || (WIDTH % MUL_BITS) != 0) begin : g_bad_mul_bits
    $error("hilo_muldiv_unit: MUL_BITS must be 1, 2 or 4 and divide WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dz;
  logic [CW-1:0]      r_cnt;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz_pend;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] r_mcand;
  // Multiplier bits (MUL) or dividend-in / quotient-out (DIV) shift register.
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvsr;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_last;
  logic               w_commit;
  logic [2*WIDTH-1:0] w_pp;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [2*WIDTH-1:0] w_prod_res;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [WIDTH-1:0]   w_quo_res;
  logic [WIDTH-1:0]   w_rem_res;

  assign busy     = (r_state != S_IDLE);
  assign op_ready = !busy;
  assign done     = r_done;
  assign div_zero = r_dz;
  assign HI_data  = r_hi;
  assign LO_data  = r_lo;

  assign w_accept = op_valid && (r_state == S_IDLE);
  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign w_is_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_a_neg  = w_signed && busA[WIDTH-1];
  assign w_b_neg  = w_signed && busB[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -busA : busA;
  assign w_b_mag  = w_b_neg ? -busB : busB;
  assign w_last   = (r_cnt == CW'(1));

  always_comb begin
    w_pp = '0;
    for (int b = 0; b < MUL_BITS; b++) begin
      if (r_q[b]) begin
        w_pp = w_pp + (r_mcand << b);
      end
    end
  end

  assign w_prod_nxt = r_prod + w_pp;
  assign w_prod_res = r_neg_q ? -w_prod_nxt : w_prod_nxt;

  // One restoring step; the partial remainder stays below the divisor, so W+1 bits suffice.
  assign w_shift   = {r_rem, r_q[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dvsr});
  assign w_diff    = w_shift[WIDTH-1:0] - r_dvsr;
  assign w_rem_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_q[WIDTH-2:0], w_ge};
  assign w_quo_res = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_res = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul) begin
          w_state_nxt = S_MUL;
        end else if (w_accept && w_is_div) begin
          w_state_nxt = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (w_last) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz_pend <= 1'b0;
      r_prod    <= '0;
      r_mcand   <= '0;
      r_q       <= '0;
      r_rem     <= '0;
      r_dvsr    <= '0;
    end else begin
      r_done <= w_commit;
      r_dz   <= w_commit && (r_state == S_DIV) && r_dz_pend;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (op)
              OP_MTLO: r_lo <= busA;
              OP_MTHI: r_hi <= busA;
              OP_MULT, OP_MULTU: begin
                r_prod  <= '0;
                r_mcand <= {{WIDTH{1'b0}}, w_a_mag};
                r_q     <= w_b_mag;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_cnt   <= CW'(N_MUL);
              end
              OP_DIV, OP_DIVU: begin
                r_rem     <= '0;
                r_q       <= w_a_mag;
                r_dvsr    <= w_b_mag;
                r_neg_q   <= w_a_neg ^ w_b_neg;
                r_neg_r   <= w_a_neg;
                r_dz_pend <= (busB == '0);
                r_cnt     <= CW'(WIDTH);
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          r_prod  <= w_prod_nxt;
          r_mcand <= r_mcand << MUL_BITS;
          r_q     <= r_q >> MUL_BITS;
          r_cnt   <= r_cnt - CW'(1);
          if (w_last) begin
            {r_hi, r_lo} <= w_prod_res;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_quo_nxt;
          r_cnt <= r_cnt - CW'(1);
          // A zero divisor still runs the full count but leaves HI/LO untouched.
          if (w_last && !r_dz_pend) begin
            r_lo <= w_quo_res;
            r_hi <= w_rem_res;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HILO_FWD_EN
  logic w_fwd_hi;
  logic w_fwd_lo;
  assign w_fwd_hi = w_accept && (op == OP_MTHI) && mulRead;
  assign w_fwd_lo = w_accept && (op == OP_MTLO) && !mulRead;
  assign HI_LOout = (w_fwd_hi || w_fwd_lo) ? busA : (mulRead ? r_hi : r_lo);
`else
  assign HI_LOout = mulRead ? r_hi : r_lo;
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized bench for hilo_muldiv_unit against a transaction-level HI/LO model.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MTLO  = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b010;
  localparam logic [2:0] OP_MULT  = 3'b011;
  localparam logic [2:0] OP_MULTU = 3'b100;
  localparam logic [2:0] OP_DIV   = 3'b101;
  localparam logic [2:0] OP_DIVU  = 3'b110;

  logic         clk = 1'b0;
  logic         Reset;
  logic         op_valid;
  logic [2:0]   op;
  logic [W-1:0] busA;
  logic [W-1:0] busB;
  logic         mulRead;
  logic [W-1:0] HI_LOout;
  logic         op_ready;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] HI_data;
  logic [W-1:0] LO_data;

  hilo_muldiv_unit #(.WIDTH(W), .MUL_BITS(1), .DIV_BITS(1)) dut (
    .clk(clk), .Reset(Reset), .op_valid(op_valid), .op(op), .busA(busA), .busB(busB),
    .mulRead(mulRead), .HI_LOout(HI_LOout), .op_ready(op_ready), .busy(busy),
    .done(done), .div_zero(div_zero), .HI_data(HI_data), .LO_data(LO_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: architectural HI/LO plus a pending result that lands after W busy cycles.
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  int           m_left;
  bit           m_done, m_dz, p_wr, p_dz;
  logic [W-1:0] exp_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_hi = '0; m_lo = '0; m_left = 0; m_done = 0; m_dz = 0; p_wr = 0; p_dz = 0;
  endtask

  task automatic compute(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo,
                         output bit wr, output bit dz);
    logic signed [63:0] sa, sb, sr;
    logic [63:0]        ua, ub, ur;
    sa = $signed(a); sb = $signed(b);
    ua = {32'b0, a}; ub = {32'b0, b};
    hi = '0; lo = '0; wr = 1; dz = 0;
    case (o)
      OP_MULT:  begin sr = sa * sb; hi = sr[63:32]; lo = sr[31:0]; end
      OP_MULTU: begin ur = ua * ub; hi = ur[63:32]; lo = ur[31:0]; end
      OP_DIV: begin
        if (b == 0) begin wr = 0; dz = 1; end
        else begin sr = sa / sb; lo = sr[31:0]; sr = sa % sb; hi = sr[31:0]; end
      end
      default: begin
        if (b == 0) begin wr = 0; dz = 1; end
        else begin ur = ua / ub; lo = ur[31:0]; ur = ua % ub; hi = ur[31:0]; end
      end
    endcase
  endtask

  task automatic model_edge(input bit v, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    m_done = 0; m_dz = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
        m_done = 1; m_dz = p_dz;
      end
    end else if (v) begin
      case (o)
        OP_MTLO: m_lo = a;
        OP_MTHI: m_hi = a;
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
          compute(o, a, b, p_hi, p_lo, p_wr, p_dz);
          m_left = W;
        end
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      exp_rd = mulRead ? m_hi : m_lo;
`ifdef HILO_FWD_EN
      if (op_valid && m_left == 0 && op == OP_MTLO && !mulRead) exp_rd = busA;
      if (op_valid && m_left == 0 && op == OP_MTHI &&  mulRead) exp_rd = busA;
`endif
      check("busy",     64'(busy),     64'(m_left > 0));
      check("op_ready", 64'(op_ready), 64'(m_left == 0));
      check("done",     64'(done),     64'(m_done));
      check("div_zero", 64'(div_zero), 64'(m_dz));
      check("HI_data",  64'(HI_data),  64'(m_hi));
      check("LO_data",  64'(LO_data),  64'(m_lo));
      check("HI_LOout", 64'(HI_LOout), 64'(exp_rd));
    end
  end

  task automatic cycle(input bit v, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit rd);
    op_valid = v; op = o; busA = a; busB = b; mulRead = rd;
    @(posedge clk); #1;
    model_edge(v, o, a, b);
  endtask

  task automatic do_reset();
    op_valid = 0;
    #2;
    Reset = 1;
    model_clear();
    #1;
    check("rst_hi",   64'(HI_data), 64'(0));
    check("rst_lo",   64'(LO_data), 64'(0));
    check("rst_busy", 64'(busy),    64'(0));
    @(posedge clk); #1;
    Reset = 0;
  endtask

  // Issue a MULT/DIV, then idle until busy falls; counts the busy cycles.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    cycle(1, o, a, b, 0);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      cycle(0, OP_NOP, '0, '0, 0);
      n++;
    end
    check("busy_cycles", 64'(n), 64'(W));
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset = 1; op_valid = 0; op = OP_NOP; busA = '0; busB = '0; mulRead = 0;
    model_clear();
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    Reset = 0;
    check("idle_read", 64'(HI_LOout), 64'(0));
    check("idle_busy", 64'(busy),     64'(0));
    check("idle_done", 64'(done),     64'(0));

    run_op(OP_MULT, 32'hFFFF_FFFF, 32'h2);
    check("mult_done", 64'(done),    64'(1));
    check("mult_hi",   64'(HI_data), 64'h0000_0000_FFFF_FFFF);
    check("mult_lo",   64'(LO_data), 64'h0000_0000_FFFF_FFFE);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
    check("multu_hi", 64'(HI_data), 64'h1);
    check("multu_lo", 64'(LO_data), 64'hFFFF_FFFE);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2);
    check("div_lo", 64'(LO_data), 64'hFFFF_FFFD);
    check("div_hi", 64'(HI_data), 64'hFFFF_FFFF);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divmin_lo", 64'(LO_data), 64'h8000_0000);
    check("divmin_hi", 64'(HI_data), 64'h0);

    cycle(1, OP_MTHI, 32'h1234, '0, 1);
    cycle(1, OP_MTLO, 32'h5678, '0, 0);
    run_op(OP_DIVU, 32'd100, 32'd0);
    check("dz_pulse", 64'(div_zero), 64'(1));
    check("dz_done",  64'(done),     64'(1));
    check("dz_hi",    64'(HI_data),  64'h1234);
    check("dz_lo",    64'(LO_data),  64'h5678);

    cycle(1, OP_MULT, 32'd3, 32'd5, 0);
    repeat (4) cycle(0, OP_NOP, '0, '0, 1);
    cycle(1, OP_MTHI, 32'hAAAA, '0, 1);
    for (int i = 0; i < 200 && busy === 1'b1; i++) cycle(0, OP_NOP, '0, '0, 1);
    check("mtblk_hi", 64'(HI_data), 64'h0);
    check("mtblk_lo", 64'(LO_data), 64'd15);
    // done is high now; the MTLO below is accepted at this same edge.
    cycle(1, OP_MTLO, 32'h77, '0, 0);
    check("b2b_lo", 64'(LO_data), 64'h77);

    cycle(1, OP_MULT, 32'h1234_5678, 32'h9ABC, 0);
    repeat (9) cycle(0, OP_NOP, '0, '0, 0);
    do_reset();
    repeat (40) cycle(0, OP_NOP, '0, '0, 0);
    check("rst_nodone_lo", 64'(LO_data), 64'h0);

    op_valid = 1; op = OP_MTLO; busA = 32'hDEAD_BEEF; busB = '0; mulRead = 0;
    #1;
`ifdef HILO_FWD_EN
    check("fwd_read", 64'(HI_LOout), 64'hDEAD_BEEF);
`else
    check("fwd_read", 64'(HI_LOout), 64'h0);
`endif
    cycle(1, OP_MTLO, 32'hDEAD_BEEF, '0, 0);
    check("fwd_after", 64'(HI_LOout), 64'hDEAD_BEEF);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), rand_val(), rand_val(),
              $urandom_range(0, 1) != 0);
      end
    end
    cycle(0, OP_NOP, '0, '0, 0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
